// File: rtl/image_scanner.sv
// 640x480@60 timing plus ROM address generator for a centred, scaled 64x64 image.
// Sync/enable flags are delayed so they line up with the ROM read data.
module image_scanner #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int IMG_X      = 192,
    parameter int IMG_Y      = 112,
    parameter int SCALE_LOG2 = 2,
    parameter int ROM_LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [11:0] rom_ad,
    input  logic [7:0]  rom_data,
    output logic [7:0]  pixel,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int IMG_W   = 64 << SCALE_LOG2;

    // Delay-line word: {hsync, vsync, de, in_img, frame_start}
    localparam logic [4:0] STAGE_IDLE = 5'b11000;

    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic [11:0] rom_ad_q, rom_ad_d;
    logic [4:0]  pipe_q [0:ROM_LAT];
    logic [4:0]  stage_d;
    logic [7:0]  pixel_q;
    logic        hsync_q, vsync_q, de_q, frame_start_q;

    logic        h_last, v_last;
    logic [10:0] x_off, y_off;
    logic        in_h, in_v, in_img;
    logic [5:0]  x_img, y_img;
    logic        hs_pulse, vs_pulse, active;

    // Next-state counters, image-window decode and ROM address selection.
    always_comb begin
        h_last = (h_q == 11'(H_TOTAL - 1));
        v_last = (v_q == 11'(V_TOTAL - 1));
        if (h_last) begin
            h_d = 11'd0;
            if (v_last) begin
                v_d = 11'd0;
            end else begin
                v_d = v_q + 11'd1;
            end
        end else begin
            h_d = h_q + 11'd1;
            v_d = v_q;
        end

        // Offsets wrap below the window, so one unsigned compare covers both edges.
        x_off  = h_q - 11'(IMG_X);
        y_off  = v_q - 11'(IMG_Y);
        in_h   = (x_off < 11'(IMG_W));
        in_v   = (y_off < 11'(IMG_W));
        in_img = in_h && in_v;
        x_img  = 6'(x_off >> SCALE_LOG2);
        y_img  = 6'(y_off >> SCALE_LOG2);

        // Outside the image the row bits hold, so the bank bit only moves at a line wrap.
        if (in_img) begin
            rom_ad_d = {y_img, x_img};
        end else if (in_v) begin
            rom_ad_d = {y_img, 6'd0};
        end else begin
            rom_ad_d = {rom_ad_q[11:6], 6'd0};
        end

        hs_pulse = (h_q >= 11'(H_ACTIVE + H_FP)) && (h_q < 11'(H_ACTIVE + H_FP + H_SYNC));
        vs_pulse = (v_q >= 11'(V_ACTIVE + V_FP)) && (v_q < 11'(V_ACTIVE + V_FP + V_SYNC));
        active   = (h_q < 11'(H_ACTIVE)) && (v_q < 11'(V_ACTIVE));
        stage_d  = {~hs_pulse, ~vs_pulse, active, in_img, (h_q == 11'd0) && (v_q == 11'd0)};
    end

    // Counters, address register, alignment delay line and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q           <= 11'd0;
            v_q           <= 11'd0;
            rom_ad_q      <= 12'd0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                pipe_q[i] <= STAGE_IDLE;
            end
            pixel_q       <= 8'h00;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            rom_ad_q  <= rom_ad_d;
            pipe_q[0] <= stage_d;
            for (int i = 1; i <= ROM_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            pixel_q       <= pipe_q[ROM_LAT][1] ? rom_data : 8'h00;
            hsync_q       <= pipe_q[ROM_LAT][4];
            vsync_q       <= pipe_q[ROM_LAT][3];
            de_q          <= pipe_q[ROM_LAT][2];
            frame_start_q <= pipe_q[ROM_LAT][0];
        end
    end

    assign rom_ad      = rom_ad_q;
    assign pixel       = pixel_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_image_scanner.sv
// Scoreboard bench for image_scanner: two reduced-timing instances (scaled x2 and
// unscaled at origin), each fed by a 2-clock ROM model, checked every clock.
module tb_image_scanner;

    localparam int HA = 160, HF = 8, HS = 16, HB = 16;
    localparam int VA = 140, VF = 3, VS = 2, VB = 5;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int AX = 8, AY = 6, AS = 1;
    localparam int BX = 0, BY = 0, BS = 0;
    localparam logic [11:0] IDLE = 12'h00C;

    logic        clk;
    logic        reset;
    logic [11:0] rom_ad_a, rom_ad_b;
    logic [7:0]  rom_data_a, rom_data_b;
    logic [7:0]  pixel_a, pixel_b;
    logic        hsync_a, vsync_a, de_a, fs_a;
    logic        hsync_b, vsync_b, de_b, fs_b;
    logic [7:0]  ra1, ra2, rb1, rb2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rel = 0;
    int h = 0, v = 0, prev_h = 0;
    int nh = 0, nv = 0, nde = 0;
    logic [11:0] ma = 12'd0, mb = 12'd0, na = 12'd0, nb = 12'd0;
    logic        last11_a = 1'b0, last11_b = 1'b0;
    logic [11:0] qa[$];
    logic [11:0] qb[$];
    int          fs_t[$];

    image_scanner #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .IMG_X(AX), .IMG_Y(AY), .SCALE_LOG2(AS), .ROM_LAT(2)
    ) u_dut_a (
        .clk(clk), .reset(reset), .rom_ad(rom_ad_a), .rom_data(rom_data_a),
        .pixel(pixel_a), .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .frame_start(fs_a)
    );

    image_scanner #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .IMG_X(BX), .IMG_Y(BY), .SCALE_LOG2(BS), .ROM_LAT(2)
    ) u_dut_b (
        .clk(clk), .reset(reset), .rom_ad(rom_ad_b), .rom_data(rom_data_b),
        .pixel(pixel_b), .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .frame_start(fs_b)
    );

    function automatic logic [7:0] rom_f(input logic [11:0] a);
        return a[7:0] ^ {4'h0, a[11:8]};
    endfunction

    // ROM models: data valid two clocks after the address register updates.
    always @(posedge clk) begin
        ra1 <= rom_f(rom_ad_a);
        ra2 <= ra1;
        rb1 <= rom_f(rom_ad_b);
        rb2 <= rb1;
    end
    assign rom_data_a = ra2;
    assign rom_data_b = rb2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] exp_out(input int hh, input int vv, input int ix, input int iy, input int s);
        int w;
        logic hs, vs, act, fs, inimg;
        logic [11:0] a;
        logic [7:0] p;
        w     = 64 << s;
        hs    = !(hh >= HA + HF && hh < HA + HF + HS);
        vs    = !(vv >= VA + VF && vv < VA + VF + VS);
        act   = (hh < HA) && (vv < VA);
        fs    = (hh == 0) && (vv == 0);
        inimg = (hh >= ix) && (hh < ix + w) && (vv >= iy) && (vv < iy + w);
        a     = {6'((vv - iy) >> s), 6'((hh - ix) >> s)};
        p     = inimg ? rom_f(a) : 8'h00;
        return {p, hs, vs, act, fs};
    endfunction

    function automatic logic [11:0] exp_ad(input int hh, input int vv, input int ix, input int iy,
                                           input int s, input logic [11:0] prev);
        int w;
        logic inh, inv;
        logic [5:0] x, y;
        w   = 64 << s;
        inh = (hh >= ix) && (hh < ix + w);
        inv = (vv >= iy) && (vv < iy + w);
        x   = 6'((hh - ix) >> s);
        y   = 6'((vv - iy) >> s);
        if (inh && inv) return {y, x};
        else if (inv)   return {y, 6'd0};
        else            return {prev[11:6], 6'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive reset, advance the reference model, compare, push expectations.
    task automatic step(input logic rst);
        logic [11:0] oa, ob;
        reset = rst;
        @(posedge clk);
        #1;
        cyc++;
        oa = {pixel_a, hsync_a, vsync_a, de_a, fs_a};
        ob = {pixel_b, hsync_b, vsync_b, de_b, fs_b};
        prev_h = h;
        if (rst) begin
            h = 0; v = 0;
            qa.delete(); qb.delete(); fs_t.delete();
            repeat (3) begin
                qa.push_back(IDLE);
                qb.push_back(IDLE);
            end
            chk("reset_out_a", oa, IDLE);
            chk("reset_out_b", ob, IDLE);
            ma = 12'd0; mb = 12'd0;
            rel = cyc; nh = 0; nv = 0; nde = 0;
        end else begin
            if (h == HT - 1) begin
                h = 0;
                v = (v == VT - 1) ? 0 : v + 1;
            end else begin
                h++;
            end
            ma = na; mb = nb;
            chk("out_a", oa, qa.pop_front());
            chk("out_b", ob, qb.pop_front());
            if (fs_a) fs_t.push_back(cyc);
            if (cyc >= rel + 4 && cyc < rel + 4 + FRAME) begin
                if (!hsync_a) nh++;
                if (!vsync_a) nv++;
                if (de_a) nde++;
            end
            if (rom_ad_a[11] != last11_a) chk("bank_edge_a", prev_h, 0);
            if (rom_ad_b[11] != last11_b) chk("bank_edge_b", prev_h, 0);
        end
        chk("rom_ad_a", rom_ad_a, ma);
        chk("rom_ad_b", rom_ad_b, mb);
        last11_a = rom_ad_a[11];
        last11_b = rom_ad_b[11];
        qa.push_back(exp_out(h, v, AX, AY, AS));
        qb.push_back(exp_out(h, v, BX, BY, BS));
        na = exp_ad(h, v, AX, AY, AS, ma);
        nb = exp_ad(h, v, BX, BY, BS, mb);
    endtask

    initial begin
        reset = 1'b1;
        repeat (5) step(1'b1);
        repeat (1500) step(1'b0);
        repeat (5) step(1'b1);
        repeat (FRAME + 10) step(1'b0);
        chk("fs_count", fs_t.size(), 2);
        chk("fs_first", (fs_t.size() > 0) ? fs_t[0] : -1, rel + 4);
        chk("fs_period", (fs_t.size() > 1) ? fs_t[1] - fs_t[0] : -1, FRAME);
        chk("hsync_low_clocks", nh, HS * VT);
        chk("vsync_low_clocks", nv, VS * HT);
        chk("de_high_clocks", nde, HA * VA);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
